// File: rtl/pwm_pkg.sv
// Shared types, constants and helpers for the PWM output peripheral.
package pwm_pkg;

    localparam int PWM_CNT_W            = 8;
    localparam int PRESCALE_DIV_DEFAULT = 13;
    localparam int NUM_OUTPUTS          = 16;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

    localparam pwm_cnt_t DUTY_OFF  = 8'h00;
    localparam pwm_cnt_t DUTY_FULL = 8'hFF;

    // How a single output pin is driven this cycle.
    typedef enum logic [1:0] {
        OUT_MODE_OFF  = 2'd0,
        OUT_MODE_HIGH = 2'd1,
        OUT_MODE_PWM  = 2'd2
    } out_mode_e;

    // Output enable wins over PWM select: a disabled pin is always low.
    function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
        out_mode_e m;
        if (!en_out) begin
            m = OUT_MODE_OFF;
        end else if (en_pwm) begin
            m = OUT_MODE_PWM;
        end else begin
            m = OUT_MODE_HIGH;
        end
        return m;
    endfunction

    // Level of the shared PWM waveform. Full-scale duty is forced high so
    // the waveform never shows a one-step low gap at the counter wrap.
    function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter shared by all PWM outputs.
// pwm_cnt advances once every PRESCALE_DIV clocks; period_start is high in
// the single cycle where both counters are zero.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = PRESCALE_DIV_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    output pwm_cnt_t pwm_cnt,
    output logic     period_start
);

    // A one-bit prescaler is kept for PRESCALE_DIV=1; it simply stays at 0.
    localparam int              PRE_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    pwm_cnt_t         pwm_cnt_q;
    pwm_cnt_t         pwm_cnt_d;
    logic             tick;

    // Next-state: prescaler wraps on tick, period counter steps on tick
    // and wraps naturally from 255 to 0.
    always_comb begin
        tick      = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    // Counter registers; reset restarts a fresh period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_cnt      = pwm_cnt_q;
    assign period_start = (pre_cnt_q == '0) && (pwm_cnt_q == '0);

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 chip outputs from the SPI-written control registers. Each pin is
// low, static high, or follows one shared PWM waveform. The duty value is
// shadowed and only taken at a period boundary so the waveform never glitches;
// enables are used live and reach the pins one clock later.
//
// Interface contract: there is no valid/ready handshake. All control inputs
// are held registers in the clk domain and are sampled on every clock edge.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = PRESCALE_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       pwm_period_start
);

    pwm_cnt_t               pwm_cnt;
    logic                   period_start;

    logic [NUM_OUTPUTS-1:0] en_out;
    logic [NUM_OUTPUTS-1:0] en_pwm;

    pwm_cnt_t               duty_shadow_q;
    pwm_cnt_t               duty_shadow_d;
    pwm_cnt_t               duty_eff;
    logic                   pwm_sig;

    logic [NUM_OUTPUTS-1:0] out_q;
    logic [NUM_OUTPUTS-1:0] out_d;
    logic                   period_start_q;

    pwm_timebase #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .pwm_cnt      (pwm_cnt),
        .period_start (period_start)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Duty selection: the period-start cycle already uses the incoming duty,
    // every other cycle uses the value captured at the last period start.
    always_comb begin
        duty_eff      = period_start ? pwm_duty_cycle : duty_shadow_q;
        duty_shadow_d = duty_eff;
        pwm_sig       = pwm_level(pwm_cnt, duty_eff);
    end

    // Per-pin output mux.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            case (out_mode(en_out[i], en_pwm[i]))
                OUT_MODE_HIGH: out_d[i] = 1'b1;
                OUT_MODE_PWM:  out_d[i] = pwm_sig;
                default:       out_d[i] = 1'b0;
            endcase
        end
    end

    // Registered duty shadow, pins and period strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shadow_q  <= DUTY_OFF;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            duty_shadow_q  <= duty_shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start;
        end
    end

    assign out_7_0          = out_q[7:0];
    assign out_15_8         = out_q[15:8];
    assign pwm_period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with the default prescaler (13).
// Period = 256*13 = 3328 clk; duty d gives d*13 high clocks per period.
`timescale 1ns/1ps

module tb_pwm_peripheral;

    localparam int CW      = 16;
    localparam int PERIOD  = 3328;
    localparam int MAX_LEN = 5000;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] out_7_0;
    logic [7:0] out_15_8;
    logic       pwm_period_start;

    always #50 clk = ~clk;

    pwm_peripheral #(
        .PRESCALE_DIV (13)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en_reg_out_7_0   (en_reg_out_7_0),
        .en_reg_out_15_8  (en_reg_out_15_8),
        .en_reg_pwm_7_0   (en_reg_pwm_7_0),
        .en_reg_pwm_15_8  (en_reg_pwm_15_8),
        .pwm_duty_cycle   (pwm_duty_cycle),
        .out_7_0          (out_7_0),
        .out_15_8         (out_15_8),
        .pwm_period_start (pwm_period_start)
    );

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic sb_push(input int v);
        exp_q.push_back(CW'(v));
    endtask

    task automatic sb_check(input string tag, input int got);
        logic [CW-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check_val(tag, CW'(got), e);
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; sample/drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        pwm_duty_cycle  = duty;
    endtask

    // Step at least once, then until the period strobe is seen (bounded).
    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (pwm_period_start !== 1'b1 && n < MAX_LEN);
        check_val({tag, "_strobe"}, CW'(pwm_period_start), 16'd1);
    endtask

    // Called on a strobe sample; walks to the next strobe sample. Counts the
    // period length, high samples of one pin and samples with any pin high.
    // Optionally rewrites the duty register at sample index chg_at.
    task automatic measure(input int bit_i, input int chg_at, input logic [7:0] chg_duty,
                           output int hi, output int len, output int nz);
        logic [15:0] o;
        hi  = 0;
        len = 0;
        nz  = 0;
        do begin
            o = {out_15_8, out_7_0};
            if (o[bit_i]) hi++;
            if (o != 16'h0000) nz++;
            if (len == chg_at) pwm_duty_cycle = chg_duty;
            len++;
            tick();
        end while (pwm_period_start !== 1'b1 && len < MAX_LEN);
    endtask

    // ---------------- stimulus ----------------
    int hi;
    int len;
    int nz;

    initial begin
        rst = 1'b1;
        set_cfg(16'h0000, 16'h0000, 8'h00);
        repeat (3) tick();
        check_val("reset_out", {out_15_8, out_7_0}, 16'h0000);
        check_val("reset_strobe", CW'(pwm_period_start), 16'd0);

        // Release: first cycle after release is a period start.
        rst = 1'b0;
        tick();
        check_val("first_strobe", CW'(pwm_period_start), 16'd1);

        // Idle: two full periods, nothing driven.
        for (int p = 0; p < 2; p++) begin
            sb_push(PERIOD);
            sb_push(0);
            measure(0, -1, 8'h00, hi, len, nz);
            sb_check("idle_len", len);
            sb_check("idle_nz", nz);
        end

        // Static high on all pins, then disable the low byte.
        set_cfg(16'hFFFF, 16'h0000, 8'h80);
        tick();
        check_val("static_on", {out_15_8, out_7_0}, 16'hFFFF);
        repeat (50) tick();
        check_val("static_hold", {out_15_8, out_7_0}, 16'hFFFF);
        en_reg_out_7_0 = 8'h00;
        #1;
        check_val("static_clr_pre", CW'(out_7_0), 16'h00FF);
        tick();
        check_val("static_clr", CW'(out_7_0), 16'h0000);
        check_val("static_keep", CW'(out_15_8), 16'h00FF);

        // PWM on pin 0 at duty 0x80, then 0x40 written at a period start.
        set_cfg(16'h0001, 16'h0001, 8'h80);
        wait_strobe("d80");
        check_val("d80_rise", {out_15_8, out_7_0}, 16'h0001);
        sb_push(1664); sb_push(PERIOD); sb_push(1664); sb_push(832);
        measure(0, -1, 8'h00, hi, len, nz);
        sb_check("d80_hi", hi);
        sb_check("d80_len", len);
        pwm_duty_cycle = 8'h40;
        measure(0, -1, 8'h00, hi, len, nz);
        sb_check("d40_shadowed_hi", hi);
        measure(0, -1, 8'h00, hi, len, nz);
        sb_check("d40_hi", hi);

        // Boundary duties on pin 15.
        set_cfg(16'h8000, 16'h8000, 8'h00);
        wait_strobe("d00");
        sb_push(0); sb_push(0);
        measure(15, -1, 8'h00, hi, len, nz);
        sb_check("d00_hi", hi);
        sb_check("d00_nz", nz);

        pwm_duty_cycle = 8'hFF;
        wait_strobe("dff");
        sb_push(PERIOD); sb_push(PERIOD); sb_push(PERIOD);
        measure(15, -1, 8'h00, hi, len, nz);
        sb_check("dff_hi_a", hi);
        measure(15, -1, 8'h00, hi, len, nz);
        sb_check("dff_hi_b", hi);
        sb_check("dff_len", len);

        pwm_duty_cycle = 8'h01;
        wait_strobe("d01");
        sb_push(13);
        measure(15, -1, 8'h00, hi, len, nz);
        sb_check("d01_hi", hi);

        // Duty 0x40 -> 0xC0 written mid-period (pwm_cnt=100).
        set_cfg(16'h0001, 16'h0001, 8'h40);
        wait_strobe("mid");
        sb_push(832); sb_push(2496);
        measure(0, 1300, 8'hC0, hi, len, nz);
        sb_check("mid_cur_hi", hi);
        measure(0, -1, 8'h00, hi, len, nz);
        sb_check("mid_next_hi", hi);

        // Reset pulse at pwm_cnt=200 with all pins high.
        set_cfg(16'hFFFF, 16'h0001, 8'hFF);
        wait_strobe("rst");
        repeat (2600) tick();
        check_val("pre_rst_out", {out_15_8, out_7_0}, 16'hFFFF);
        rst = 1'b1;
        tick();
        check_val("rst_out", {out_15_8, out_7_0}, 16'h0000);
        check_val("rst_strobe", CW'(pwm_period_start), 16'd0);
        rst = 1'b0;
        tick();
        check_val("restart_strobe", CW'(pwm_period_start), 16'd1);
        check_val("restart_out", {out_15_8, out_7_0}, 16'hFFFF);
        sb_push(PERIOD); sb_push(PERIOD);
        measure(0, -1, 8'h00, hi, len, nz);
        sb_check("restart_len", len);
        sb_check("restart_hi", hi);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
